sram_arbiter: RTL
=================

# sram_arbiter

Two-requester arbiter that shares one single-port SRAM-like memory bus between the CPU instruction-fetch path and the load/store path. It sits between the core (`inst_sram_*` / `data_sram_*` request sources) and the unified memory port. It sequences one outstanding transaction at a time with an address-phase/data-phase handshake. Data requests have priority, and a starvation guard forces periodic fetch grants.

## Interface
- `STARVE_LIMIT`, default 4: consecutive data grants, each taken while an inst request was pending, after which a contested cycle is granted to inst.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `inst_req` input 1: fetch request valid.
- `inst_addr` input 32: fetch address.
- `inst_addr_ok` output 1: fetch request accepted this cycle.
- `inst_data_ok` output 1: fetch data valid this cycle.
- `inst_rdata` output 32: fetch data.
- `data_req` input 1: load/store request valid.
- `data_we` input 1: 1 = store.
- `data_wstrb` input 4: byte strobes for stores.
- `data_addr` input 32: load/store address.
- `data_wdata` input 32: store data.
- `data_addr_ok` output 1: load/store accepted this cycle.
- `data_data_ok` output 1: load data valid or store complete this cycle.
- `data_rdata` output 32: load data.
- `mem_req` output 1: memory request valid.
- `mem_we` output 1: memory write.
- `mem_wstrb` output 4: memory byte strobes.
- `mem_addr` output 32: memory address.
- `mem_wdata` output 32: memory write data.
- `mem_addr_ok` input 1: memory accepted the address phase.
- `mem_data_ok` input 1: memory completed the data phase.
- `mem_rdata` input 32: memory read data.

## Operation
- FSM states: IDLE, REQ, WAIT. The owner register is 1 bit (0 = inst, 1 = data).
- IDLE, no request: stay in IDLE; all handshake outputs 0.
- IDLE, request present: select the winner.
  - Winner is data if `data_req`, unless `inst_req` is also set and `starve_cnt == STARVE_LIMIT`, in which case the winner is inst.
  - Winner is inst if only `inst_req` is set.
- On selection:
  - Pulse the winner's `*_addr_ok` combinationally in the same cycle.
  - Latch owner, addr, we, wstrb and wdata into the memory-side registers.
  - Go to REQ.
  - A fetch latches `we = 0` and `wstrb = 0`.
- REQ: `mem_req = 1` with the latched fields held stable. On `mem_addr_ok`, drop `mem_req` next cycle and go to WAIT.
- WAIT: `mem_req = 0`. On `mem_data_ok`:
  - Drive the owner's `*_data_ok = 1` and `*_rdata = mem_rdata` combinationally.
  - Go to IDLE.
- Non-owner `*_rdata` is 0. `mem_data_ok` outside WAIT is ignored.
- No request is accepted in REQ or WAIT; `*_addr_ok` stays 0 there. Requesters hold `req` and fields until they see `addr_ok`.
- `starve_cnt` is 3 bits wide, saturating at `STARVE_LIMIT`, and updates only on a grant:
  - Data granted while `inst_req` = 1: increment.
  - Data granted while `inst_req` = 0: clear.
  - Inst granted: clear.

## Timing
- Reset values:
  - state = IDLE, `starve_cnt` = 0, owner = 0.
  - `mem_req` = 0 and `mem_we` = 0.
  - `mem_wstrb`, `mem_addr` and `mem_wdata` = 0.
  - All `*_addr_ok`, `*_data_ok` and `*_rdata` = 0.
- Minimum latency, with memory `addr_ok` and `data_ok` each in their first eligible cycle: accept at cycle 0, `mem_req` at cycle 1, `data_ok` at cycle 2. Back-to-back accepts are 3 cycles apart.
- Memory-side outputs are registered. Requester-side outputs are combinational from state, owner and memory inputs.
- Reset asserted mid-transaction: forced to IDLE immediately and `mem_req` drops asynchronously. The in-flight access is abandoned, and any later `mem_data_ok` is ignored.
- Simultaneous requests in IDLE: exactly one `addr_ok` pulses; the loser's request stays pending.

## Structure
- Shared package `sram_arb_pkg`:
  - state enum: IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2.
  - owner constants: OWN_INST = 1'b0, OWN_DATA = 1'b1.
- One sub-module, `arb_starve_ctr`: the saturating counter, with inputs `grant`, `grant_is_data`, `other_pending` and output `at_limit`. The rest is flat.

## Test plan
- Single fetch: `inst_req`, `inst_addr = 0x1c000000`, memory returns 0x02800404 with zero wait states.
  - `inst_addr_ok` at cycle 0.
  - `mem_req` at cycle 1 with `mem_addr = 0x1c000000`.
  - `inst_data_ok` with `inst_rdata = 0x02800404` at cycle 2.
- Store: `data_we = 1`, `wstrb = 0xF`, `addr = 0x1c001000`, `wdata = 0xdeadbeef`, memory delays `addr_ok` by 3 cycles.
  - `mem_req` is held with stable fields for 4 cycles.
  - `data_data_ok` follows `mem_data_ok`.
  - `inst_data_ok` stays 0.
- Contention: `inst_req` and `data_req` held high continuously with `STARVE_LIMIT = 4`.
  - Grant sequence is D, D, D, D, I, D, D, D, D, I.
- Inst starvation counter clear: a data grant taken with `inst_req = 0` resets the count.
  - The next contested cycles then need 4 more data grants before inst is granted.
- Async reset asserted during WAIT:
  - `mem_req` and all outputs are 0 immediately and state is IDLE.
  - A `mem_data_ok` pulse after reset produces no requester `data_ok`.
- Memory asserts `mem_data_ok` while in IDLE or REQ: ignored, no `*_data_ok`.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the two-requester SRAM bus arbiter.
package sram_arb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundles the fetch, load/store and unified memory handshakes seen by the arbiter.
interface sram_arbiter_if;
  import sram_arb_pkg::*;

  logic              inst_req;
  logic [DATA_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  logic              data_req;
  logic              data_we;
  logic [STRB_W-1:0] data_wstrb;
  logic [DATA_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [STRB_W-1:0] mem_wstrb;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view: serves the core requesters, drives the memory port.
  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_we, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  // Environment view: core requesters plus the memory responder.
  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_we, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );

endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
module arb_starve_ctr
  import sram_arb_pkg::*;
#(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic grant,
  input  logic grant_is_data,
  input  logic other_pending,
  output logic at_limit
);

  localparam logic [CNT_W-1:0] LimitCnt = CNT_W'(LIMIT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (grant) begin
      if (grant_is_data && other_pending) begin
        if (r_cnt != LimitCnt) r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign at_limit = (r_cnt == LimitCnt);

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-port memory bus between fetch and load/store, one transaction at a time.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  sram_arbiter_if.slave  bus
);

  arb_state_e        r_state, w_state_nxt;
  logic              r_owner;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [STRB_W-1:0] r_mem_wstrb;
  logic [DATA_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic w_any_req, w_grant, w_grant_data, w_at_limit, w_resp;

  assign w_any_req    = bus.inst_req | bus.data_req;
  assign w_grant      = (r_state == IDLE) && w_any_req;
  // Data wins unless the fetch has been passed over STARVE_LIMIT times in a row.
  assign w_grant_data = bus.data_req && !(bus.inst_req && w_at_limit);

  arb_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk          (clk),
    .reset        (reset),
    .grant        (w_grant),
    .grant_is_data(w_grant_data),
    .other_pending(bus.inst_req),
    .at_limit     (w_at_limit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_any_req)       w_state_nxt = REQ;
      REQ:     if (bus.mem_addr_ok) w_state_nxt = WAIT;
      WAIT:    if (bus.mem_data_ok) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_resp           = (r_state == WAIT) && bus.mem_data_ok;
    bus.inst_addr_ok = w_grant && !w_grant_data;
    bus.data_addr_ok = w_grant && w_grant_data;
    bus.inst_data_ok = w_resp && (r_owner == OWN_INST);
    bus.data_data_ok = w_resp && (r_owner == OWN_DATA);
    bus.inst_rdata   = bus.inst_data_ok ? bus.mem_rdata : '0;
    bus.data_rdata   = bus.data_data_ok ? bus.mem_rdata : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner     <= OWN_INST;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_wstrb <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_grant) begin
      r_mem_req <= 1'b1;
      if (w_grant_data) begin
        r_owner     <= OWN_DATA;
        r_mem_we    <= bus.data_we;
        r_mem_wstrb <= bus.data_wstrb;
        r_mem_addr  <= bus.data_addr;
        r_mem_wdata <= bus.data_wdata;
      end else begin
        r_owner     <= OWN_INST;
        r_mem_we    <= 1'b0;
        r_mem_wstrb <= '0;
        r_mem_addr  <= bus.inst_addr;
        r_mem_wdata <= '0;
      end
    end else if ((r_state == REQ) && bus.mem_addr_ok) begin
      r_mem_req <= 1'b0;
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_wstrb = r_mem_wstrb;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule
